memory_turn_ctrl: RTL and testbench
===================================

MEMORY_TURN_CTRL -- requirements
Module: memory_turn_ctrl

Interface
REQ-001 Parameter SHUFFLE_CYCLES, default 8, sets the number of cycles shuffle_en is held high per game.
REQ-002 Parameter HOLD_CYCLES, default 4, sets the number of cycles a revealed pair stays visible before it is resolved.
REQ-003 Parameter MAX_MOVES, default 12, sets the move limit, used only under MOVE_LIMIT_EN.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; begins a new game from IDLE or DONE.
REQ-007 sel_valid  in  1  one-cycle card-selection strobe.
REQ-008 sel_idx  in  3  selected card index, valid range 0..5.
REQ-009 faces  in  24  card faces from the pair generator, packed {F,E,D,C,B,A}, 4 bits each.
REQ-010 shuffle_en  out  1  enable to the pair generator.
REQ-011 reveal_mask  out  6  cards currently face-up but not yet matched.
REQ-012 matched_mask  out  6  cards already matched.
REQ-013 moves  out  8  count of completed pair attempts.
REQ-014 match_pulse / miss_pulse  out  1 each  one-cycle result strobes.
REQ-015 game_over  out  1  high in DONE.
REQ-016 game_won  out  1  high in DONE when all six cards are matched.

Function
REQ-017 States: IDLE, SHUFFLE, PICK1, PICK2, SHOW, CHECK, DONE.
REQ-018 IDLE->SHUFFLE on start; shuffle_en=1 for exactly SHUFFLE_CYCLES cycles, then ->PICK1; on that entry clear both masks and moves.
REQ-019 PICK1: accept sel_valid only if sel_idx<=5 and the card is not matched; on accept set reveal_mask bit, latch index as first, ->PICK2.
REQ-020 PICK2: accept sel_valid only if sel_idx<=5, the card is not matched, and sel_idx differs from first; on accept set the reveal bit, latch as second, ->SHOW.
REQ-021 Rejected selections are ignored, with no state, mask or counter change.
REQ-022 SHOW: hold for HOLD_CYCLES cycles, ignoring sel_valid, then ->CHECK.
REQ-023 CHECK lasts one cycle: moves+1, saturating at 255.
REQ-024 CHECK, faces equal: set both matched bits, clear both reveal bits, pulse match_pulse.
REQ-025 CHECK, faces differ: clear both reveal bits, pulse miss_pulse.
REQ-026 CHECK next state: DONE if matched_mask becomes 6'b111111, else PICK1.
REQ-027 A face comparison uses the faces sampled in CHECK; faces changing outside SHUFFLE are not guarded.
REQ-028 DONE: masks and moves hold; start ->SHUFFLE; start is ignored in every other state except IDLE.
REQ-029 sel_valid in IDLE, SHUFFLE, SHOW, CHECK or DONE is ignored.

Reset
REQ-030 rst=1 at any clock edge, including mid-SHUFFLE or mid-SHOW, forces IDLE next cycle with all outputs 0 and timers cleared.

Configuration
REQ-031 With MOVE_LIMIT_EN defined: CHECK ->DONE with game_won=0 when moves reaches MAX_MOVES and matched_mask is not full; a full mask at that same CHECK gives DONE with game_won=1.
REQ-032 Without MOVE_LIMIT_EN: no limit, MAX_MOVES is unused, and the game ends only on a full match.

Structure
REQ-033 Shared package mem_game_pkg holds the state enum, NUM_CARDS=6, FACE_W=4 and the full-mask constant.
REQ-034 One sub-module, game_timer: a loadable down-counter with a done flag, reused for SHUFFLE and SHOW.

Verification
REQ-035 rst, then start=1 for one cycle -> shuffle_en high exactly 8 cycles, then state PICK1 with moves=0.
REQ-036 faces A=1,B=1; select 0 then 1 -> reveal_mask=000011 for 4 cycles, then match_pulse, matched_mask=000011, moves=1.
REQ-037 faces A=1,C=2; select 0 then 2 -> miss_pulse, reveal_mask=0, matched_mask unchanged, moves=1.
REQ-038 Select 0, 0 again, then 7, then an already-matched card -> all ignored, still PICK2 with reveal_mask=000001.
REQ-039 Solve all three pairs in 3 moves -> game_over=1, game_won=1, matched_mask=111111; rst asserted during SHOW of a later game -> IDLE and all outputs 0.
REQ-040 With MOVE_LIMIT_EN and MAX_MOVES=2: two misses -> game_over=1, game_won=0, moves=2.

Source files
------------

// File: rtl/mem_game_pkg.sv
// mem_game_pkg: shared types, sizes and helpers for the memory-game turn controller.
package mem_game_pkg;

   localparam int NUM_CARDS = 6;
   localparam int FACE_W    = 4;
   localparam int TIMER_W   = 8;

   localparam logic [NUM_CARDS-1:0] FULL_MASK = 6'b111111;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SHUFFLE = 3'd1,
      ST_PICK1   = 3'd2,
      ST_PICK2   = 3'd3,
      ST_SHOW    = 3'd4,
      ST_CHECK   = 3'd5,
      ST_DONE    = 3'd6
   } state_e;

   function automatic logic [FACE_W-1:0] face_at(
      input logic [NUM_CARDS*FACE_W-1:0] faces,
      input logic [2:0]                  idx
   );
      logic [FACE_W-1:0] f;
      f = 4'd0;
      case (idx)
         3'd0:    f = faces[3:0];
         3'd1:    f = faces[7:4];
         3'd2:    f = faces[11:8];
         3'd3:    f = faces[15:12];
         3'd4:    f = faces[19:16];
         3'd5:    f = faces[23:20];
         default: f = 4'd0;
      endcase
      return f;
   endfunction

   // One-hot card bit; out-of-range indices map to no card at all.
   function automatic logic [NUM_CARDS-1:0] card_bit(input logic [2:0] idx);
      logic [NUM_CARDS-1:0] b;
      if (idx <= 3'd5) begin
         b = 6'b000001 << idx;
      end else begin
         b = 6'b000000;
      end
      return b;
   endfunction

endpackage

// File: rtl/memory_turn_ctrl_game_timer.sv
// game_timer: loadable down-counter; done is high while the count is at its last cycle (or idle at zero).
module game_timer #(
   parameter int W = 8
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != W'(0))) begin
         cnt_d = cnt_q - W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= W'(0);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q <= W'(1));

endmodule

// File: rtl/memory_turn_ctrl.sv
// memory_turn_ctrl: turn sequencer for a six-card memory game (shuffle, two picks, show, check).
// Optional feature: define MOVE_LIMIT_EN to end a game as lost once MAX_MOVES pair attempts are used.
module memory_turn_ctrl
   import mem_game_pkg::*;
#(
   parameter int SHUFFLE_CYCLES = 8,
   parameter int HOLD_CYCLES    = 4,
   parameter int MAX_MOVES      = 12
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        sel_valid,
   input  logic [2:0]  sel_idx,
   input  logic [23:0] faces,
   output logic        shuffle_en,
   output logic [5:0]  reveal_mask,
   output logic [5:0]  matched_mask,
   output logic [7:0]  moves,
   output logic        match_pulse,
   output logic        miss_pulse,
   output logic        game_over,
   output logic        game_won
);

`ifdef MOVE_LIMIT_EN
   localparam logic LIMIT_EN = 1'b1;
`else
   localparam logic LIMIT_EN = 1'b0;
`endif

   state_e      state_q, state_d;
   logic [2:0]  first_q, first_d;
   logic [2:0]  second_q, second_d;
   logic [5:0]  reveal_q, reveal_d;
   logic [5:0]  matched_q, matched_d;
   logic [7:0]  moves_q, moves_d;
   logic        match_pulse_q, match_pulse_d;
   logic        miss_pulse_q, miss_pulse_d;
   logic        shuffle_en_q, shuffle_en_d;
   logic        game_over_q, game_over_d;
   logic        game_won_q, game_won_d;

   logic               timer_load;
   logic               timer_en;
   logic [TIMER_W-1:0] timer_val;
   logic               timer_done;

   logic [7:0] matched_ext;
   logic       sel_ok;
   logic [5:0] pair_bits;
   logic       limit_hit;

   game_timer #(.W(TIMER_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .en       (timer_en),
      .load_val (timer_val),
      .done     (timer_done)
   );

   assign matched_ext = {2'b00, matched_q};
   assign sel_ok      = sel_valid && (sel_idx <= 3'd5) && !matched_ext[sel_idx];
   assign pair_bits   = card_bit(first_q) | card_bit(second_q);

   always_comb begin
      state_d       = state_q;
      first_d       = first_q;
      second_d      = second_q;
      reveal_d      = reveal_q;
      matched_d     = matched_q;
      moves_d       = moves_q;
      match_pulse_d = 1'b0;
      miss_pulse_d  = 1'b0;
      timer_load    = 1'b0;
      timer_en      = 1'b0;
      timer_val     = TIMER_W'(SHUFFLE_CYCLES);
      limit_hit     = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_SHUFFLE;
               timer_load = 1'b1;
               timer_val  = TIMER_W'(SHUFFLE_CYCLES);
            end else begin
               state_d = state_q;
            end
         end
         ST_SHUFFLE: begin
            timer_en = 1'b1;
            if (timer_done) begin
               state_d   = ST_PICK1;
               reveal_d  = 6'b000000;
               matched_d = 6'b000000;
               moves_d   = 8'd0;
            end else begin
               state_d = ST_SHUFFLE;
            end
         end
         ST_PICK1: begin
            if (sel_ok) begin
               reveal_d = reveal_q | card_bit(sel_idx);
               first_d  = sel_idx;
               state_d  = ST_PICK2;
            end else begin
               state_d = ST_PICK1;
            end
         end
         ST_PICK2: begin
            if (sel_ok && (sel_idx != first_q)) begin
               reveal_d   = reveal_q | card_bit(sel_idx);
               second_d   = sel_idx;
               state_d    = ST_SHOW;
               timer_load = 1'b1;
               timer_val  = TIMER_W'(HOLD_CYCLES);
            end else begin
               state_d = ST_PICK2;
            end
         end
         ST_SHOW: begin
            timer_en = 1'b1;
            if (timer_done) begin
               state_d = ST_CHECK;
            end else begin
               state_d = ST_SHOW;
            end
         end
         ST_CHECK: begin
            moves_d  = (moves_q == 8'hFF) ? 8'hFF : (moves_q + 8'd1);
            reveal_d = reveal_q & ~pair_bits;
            if (face_at(faces, first_q) == face_at(faces, second_q)) begin
               matched_d     = matched_q | pair_bits;
               match_pulse_d = 1'b1;
            end else begin
               miss_pulse_d  = 1'b1;
            end
            limit_hit = LIMIT_EN && ({24'd0, moves_d} >= 32'(MAX_MOVES));
            if ((matched_d == FULL_MASK) || limit_hit) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_PICK1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status outputs are registered from the next state so they line up with the masks.
      shuffle_en_d = (state_d == ST_SHUFFLE);
      game_over_d  = (state_d == ST_DONE);
      game_won_d   = (state_d == ST_DONE) && (matched_d == FULL_MASK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         first_q       <= 3'd0;
         second_q      <= 3'd0;
         reveal_q      <= 6'b000000;
         matched_q     <= 6'b000000;
         moves_q       <= 8'd0;
         match_pulse_q <= 1'b0;
         miss_pulse_q  <= 1'b0;
         shuffle_en_q  <= 1'b0;
         game_over_q   <= 1'b0;
         game_won_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         first_q       <= first_d;
         second_q      <= second_d;
         reveal_q      <= reveal_d;
         matched_q     <= matched_d;
         moves_q       <= moves_d;
         match_pulse_q <= match_pulse_d;
         miss_pulse_q  <= miss_pulse_d;
         shuffle_en_q  <= shuffle_en_d;
         game_over_q   <= game_over_d;
         game_won_q    <= game_won_d;
      end
   end

   assign shuffle_en   = shuffle_en_q;
   assign reveal_mask  = reveal_q;
   assign matched_mask = matched_q;
   assign moves        = moves_q;
   assign match_pulse  = match_pulse_q;
   assign miss_pulse   = miss_pulse_q;
   assign game_over    = game_over_q;
   assign game_won     = game_won_q;

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// tb_memory_turn_ctrl: directed, table-driven bench; a second instance with MAX_MOVES=2 covers the move limit.
module tb_memory_turn_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, start_l, sel_valid;
   logic [2:0]  sel_idx;
   logic [23:0] faces;

   logic       shuffle_en, match_pulse, miss_pulse, game_over, game_won;
   logic [5:0] reveal_mask, matched_mask;
   logic [7:0] moves;

   logic       shuffle_en_l, match_pulse_l, miss_pulse_l, game_over_l, game_won_l;
   logic [5:0] reveal_mask_l, matched_mask_l;
   logic [7:0] moves_l;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       sv;
      logic [2:0] si;
      logic [5:0] rev;
      logic [5:0] mat;
      logic [7:0] mov;
      logic       mp;
      logic       xp;
      logic       ov;
      logic       wn;
   } vec_t;

   vec_t tbl[$];

   memory_turn_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .sel_valid(sel_valid), .sel_idx(sel_idx),
      .faces(faces), .shuffle_en(shuffle_en), .reveal_mask(reveal_mask),
      .matched_mask(matched_mask), .moves(moves), .match_pulse(match_pulse),
      .miss_pulse(miss_pulse), .game_over(game_over), .game_won(game_won)
   );

   memory_turn_ctrl #(.MAX_MOVES(2)) dut_lim (
      .clk(clk), .rst(rst), .start(start_l), .sel_valid(sel_valid), .sel_idx(sel_idx),
      .faces(faces), .shuffle_en(shuffle_en_l), .reveal_mask(reveal_mask_l),
      .matched_mask(matched_mask_l), .moves(moves_l), .match_pulse(match_pulse_l),
      .miss_pulse(miss_pulse_l), .game_over(game_over_l), .game_won(game_won_l)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic sv, input logic [2:0] si, input logic [5:0] rev,
                      input logic [5:0] mat, input logic [7:0] mov,
                      input logic mp, input logic xp, input logic ov, input logic wn);
      vec_t v;
      v.sv = sv; v.si = si; v.rev = rev; v.mat = mat; v.mov = mov;
      v.mp = mp; v.xp = xp; v.ov = ov; v.wn = wn;
      tbl.push_back(v);
   endtask

   task automatic step(input logic v, input logic [2:0] i);
      sel_valid = v;
      sel_idx   = i;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Pulses start for one edge, then counts cycles with shuffle_en high (bounded).
   task automatic run_shuffle(input bit lim, output int n);
      n = 0;
      if (lim) start_l = 1'b1;
      else     start   = 1'b1;
      step(1'b0, 3'd0);
      start   = 1'b0;
      start_l = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if ((lim ? shuffle_en_l : shuffle_en) !== 1'b1) break;
         n++;
         step(1'b0, 3'd0);
      end
   endtask

   task automatic do_pair(input logic [2:0] a, input logic [2:0] b);
      step(1'b1, a);
      step(1'b1, b);
      repeat (5) step(1'b0, 3'd0);
   endtask

   initial begin
      int n;
      faces = 24'h332211;   // A=B=1, C=D=2, E=F=3
      rst = 1'b1; start = 1'b0; start_l = 1'b0; sel_valid = 1'b0; sel_idx = 3'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_shuffle", shuffle_en, 1'b0);
      chk("rst_reveal",  reveal_mask, 6'd0);
      chk("rst_matched", matched_mask, 6'd0);
      chk("rst_moves",   moves, 8'd0);
      chk("rst_over",    {game_over, game_won, match_pulse, miss_pulse}, 4'd0);
      rst = 1'b0;

      step(1'b1, 3'd0);
      chk("idle_sel_ignored", reveal_mask, 6'd0);

      run_shuffle(1'b0, n);
      chk("shuffle_len_g1", n, 8);
      chk("pick1_moves", moves, 8'd0);

      //  sv  si     rev       mat       mov  mp  xp  ov  wn
      add(1, 3'd0, 6'h01, 6'h00, 8'd0, 0, 0, 0, 0);
      add(1, 3'd0, 6'h01, 6'h00, 8'd0, 0, 0, 0, 0);
      add(1, 3'd7, 6'h01, 6'h00, 8'd0, 0, 0, 0, 0);
      add(0, 3'd0, 6'h01, 6'h00, 8'd0, 0, 0, 0, 0);
      add(1, 3'd1, 6'h03, 6'h00, 8'd0, 0, 0, 0, 0);
      add(1, 3'd2, 6'h03, 6'h00, 8'd0, 0, 0, 0, 0);
      add(1, 3'd3, 6'h03, 6'h00, 8'd0, 0, 0, 0, 0);
      add(0, 3'd0, 6'h03, 6'h00, 8'd0, 0, 0, 0, 0);
      add(0, 3'd0, 6'h03, 6'h00, 8'd0, 0, 0, 0, 0);
      add(1, 3'd2, 6'h00, 6'h03, 8'd1, 1, 0, 0, 0);
      add(0, 3'd0, 6'h00, 6'h03, 8'd1, 0, 0, 0, 0);
      add(1, 3'd1, 6'h00, 6'h03, 8'd1, 0, 0, 0, 0);
      add(1, 3'd6, 6'h00, 6'h03, 8'd1, 0, 0, 0, 0);
      add(1, 3'd2, 6'h04, 6'h03, 8'd1, 0, 0, 0, 0);
      add(1, 3'd1, 6'h04, 6'h03, 8'd1, 0, 0, 0, 0);
      add(1, 3'd2, 6'h04, 6'h03, 8'd1, 0, 0, 0, 0);
      add(1, 3'd4, 6'h14, 6'h03, 8'd1, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) add(0, 3'd0, 6'h14, 6'h03, 8'd1, 0, 0, 0, 0);
      add(0, 3'd0, 6'h00, 6'h03, 8'd2, 0, 1, 0, 0);
      add(1, 3'd2, 6'h04, 6'h03, 8'd2, 0, 0, 0, 0);
      add(1, 3'd3, 6'h0C, 6'h03, 8'd2, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) add(0, 3'd0, 6'h0C, 6'h03, 8'd2, 0, 0, 0, 0);
      add(0, 3'd0, 6'h00, 6'h0F, 8'd3, 1, 0, 0, 0);
      add(1, 3'd5, 6'h20, 6'h0F, 8'd3, 0, 0, 0, 0);
      add(1, 3'd4, 6'h30, 6'h0F, 8'd3, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) add(0, 3'd0, 6'h30, 6'h0F, 8'd3, 0, 0, 0, 0);
      add(0, 3'd0, 6'h00, 6'h3F, 8'd4, 1, 0, 1, 1);
      add(1, 3'd0, 6'h00, 6'h3F, 8'd4, 0, 0, 1, 1);

      for (int k = 0; k < tbl.size(); k++) begin
         step(tbl[k].sv, tbl[k].si);
         chk($sformatf("v%0d_reveal", k),  reveal_mask,  tbl[k].rev);
         chk($sformatf("v%0d_matched", k), matched_mask, tbl[k].mat);
         chk($sformatf("v%0d_moves", k),   moves,        tbl[k].mov);
         chk($sformatf("v%0d_pulses", k),  {match_pulse, miss_pulse}, {tbl[k].mp, tbl[k].xp});
         chk($sformatf("v%0d_end", k),     {game_over, game_won},     {tbl[k].ov, tbl[k].wn});
      end

      // Game 2 from DONE: restart clears state, start ignored in PICK1, solve in three moves.
      run_shuffle(1'b0, n);
      chk("shuffle_len_g2", n, 8);
      chk("g2_cleared", {matched_mask, moves, game_over}, {6'd0, 8'd0, 1'b0});
      start = 1'b1;
      step(1'b0, 3'd0);
      start = 1'b0;
      chk("g2_start_ignored", shuffle_en, 1'b0);
      do_pair(3'd0, 3'd1);
      chk("g2_pair1", {match_pulse, matched_mask, moves}, {1'b1, 6'h03, 8'd1});
      do_pair(3'd3, 3'd2);
      do_pair(3'd4, 3'd5);
      chk("g2_matched", matched_mask, 6'h3F);
      chk("g2_moves", moves, 8'd3);
      chk("g2_won", {game_over, game_won, reveal_mask}, {1'b1, 1'b1, 6'd0});

      // Game 3: reset while the pair is on show.
      run_shuffle(1'b0, n);
      chk("shuffle_len_g3", n, 8);
      step(1'b1, 3'd0);
      step(1'b1, 3'd1);
      step(1'b0, 3'd0);
      chk("g3_show_reveal", reveal_mask, 6'h03);
      rst = 1'b1;
      step(1'b0, 3'd0);
      rst = 1'b0;
      chk("g3_rst_masks", {reveal_mask, matched_mask, moves}, 20'd0);
      chk("g3_rst_flags", {shuffle_en, game_over, game_won, match_pulse, miss_pulse}, 5'd0);
      repeat (6) step(1'b1, 3'd0);
      chk("g3_idle_after_rst", {shuffle_en, reveal_mask, match_pulse, miss_pulse}, 9'd0);

      // Move limit instance: two misses.
      run_shuffle(1'b1, n);
      chk("shuffle_len_lim", n, 8);
      do_pair(3'd0, 3'd2);
      chk("lim_miss1", {miss_pulse_l, moves_l, game_over_l}, {1'b1, 8'd1, 1'b0});
      do_pair(3'd1, 3'd3);
      chk("lim_moves", moves_l, 8'd2);
      chk("lim_matched", matched_mask_l, 6'd0);
`ifdef MOVE_LIMIT_EN
      chk("lim_over", {game_over_l, game_won_l}, {1'b1, 1'b0});
      step(1'b1, 3'd0);
      chk("lim_done_ignores_sel", reveal_mask_l, 6'd0);
`else
      chk("nolim_over", {game_over_l, game_won_l}, {1'b0, 1'b0});
      step(1'b1, 3'd0);
      chk("nolim_still_playing", reveal_mask_l, 6'h01);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
